tmc_nios2_mtimer: RTL and testbench

TMC_NIOS2_MTIMER -- requirements
Module: tmc_nios2_mtimer

---
 rtl/tmc_nios2_mtimer_pkg.sv | 23 ++
 rtl/tmc_nios2_mtimer_ch.sv | 62 ++++++
 rtl/tmc_nios2_mtimer.sv | 59 +++++
 tb/tb_tmc_nios2_mtimer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tmc_nios2_mtimer_pkg.sv
// tmc_nios2_mtimer_pkg: register offsets, CONTROL/STATUS bit positions and the per-channel register view
package tmc_nios2_mtimer_pkg;
    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD   = 3'd2;
    localparam logic [2:0] REG_SNAPSHOT = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;
    localparam int STAT_TO    = 0;
    localparam int STAT_RUN   = 1;
    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;
    typedef struct packed {
        logic [31:0] period;
        logic [31:0] snapshot;
        logic [15:0] prescale;
        logic        ito;
        logic        cont;
        logic        to;
        logic        run;
    } ch_regs_t;
endpackage

// File: rtl/tmc_nios2_mtimer_ch.sv
// tmc_nios2_mtimer_ch: one timer channel; clk/reset_n, wr+offset+writedata register write, regs = readable state
module tmc_nios2_mtimer_ch
    import tmc_nios2_mtimer_pkg::*;
#(
    parameter int          CNT_W        = 32,
    parameter int          PRE_W        = 8,
    parameter logic [31:0] RESET_PERIOD = 32'h08F0D17F
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr,
    input  logic [2:0]  offset,
    input  logic [31:0] writedata,
    output ch_regs_t    regs
);
    logic [CNT_W-1:0] cnt, period, snapshot;
    logic [PRE_W-1:0] prescale, prescale_act, psc;
    logic ito, cont, to, run, zero_q, reload;
    logic wr_ctrl, tick, timeout, hold, run_next;

    assign wr_ctrl  = wr & (offset == REG_CONTROL);
    assign tick     = run & (psc == prescale_act);
    assign timeout  = (cnt == '0) & ~zero_q;
    // a one-shot timeout parks the counter at zero instead of reloading
    assign hold     = timeout & ~cont;
    assign run_next = (wr_ctrl & writedata[CTRL_START]) |
                      (run & ~hold & ~reload & ~(wr_ctrl & writedata[CTRL_STOP]));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt          <= RESET_PERIOD[CNT_W-1:0];
            period       <= RESET_PERIOD[CNT_W-1:0];
            snapshot     <= '0;
            prescale     <= '0;
            prescale_act <= '0;
            psc          <= '0;
            ito          <= 1'b0;
            cont         <= 1'b0;
            to           <= 1'b0;
            run          <= 1'b0;
            zero_q       <= 1'b1;
            reload       <= 1'b0;
        end else begin
            zero_q       <= cnt == '0;
            reload       <= wr & (offset == REG_PERIOD);
            run          <= run_next;
            to           <= timeout | (to & ~(wr & (offset == REG_STATUS) & writedata[STAT_TO]));
            psc          <= (~run | reload | tick) ? '0 : psc + PRE_W'(1);
            // new PRESCALE is adopted at a wrap, or straight away while stopped
            prescale_act <= (tick | ~run) ? prescale : prescale_act;
            cnt          <= reload ? period :
                            (tick & ~hold) ? ((cnt == '0) ? period : cnt - CNT_W'(1)) : cnt;
            if (wr_ctrl) {cont, ito} <= writedata[CTRL_CONT:CTRL_ITO];
            if (wr & (offset == REG_PERIOD)) period <= writedata[CNT_W-1:0];
            if (wr & (offset == REG_SNAPSHOT)) snapshot <= cnt;
            if (wr & (offset == REG_PRESCALE)) prescale <= writedata[PRE_W-1:0];
        end
    end

    assign regs = '{period: 32'(period), snapshot: 32'(snapshot), prescale: 16'(prescale),
                    ito: ito, cont: cont, to: to, run: run};
endmodule

// File: rtl/tmc_nios2_mtimer.sv
// tmc_nios2_mtimer: N_CH-channel timer; clk/reset_n, Avalon-style slave (address, chipselect, write_n, writedata, readdata), irq/irq_vec
module tmc_nios2_mtimer
    import tmc_nios2_mtimer_pkg::*;
#(
    parameter int          N_CH         = 4,
    parameter int          CNT_W        = 32,
    parameter int          PRE_W        = 8,
    parameter logic [31:0] RESET_PERIOD = 32'h08F0D17F,
    localparam int         CW           = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int         AW           = 3 + CW
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   address,
    input  logic            chipselect,
    input  logic            write_n,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    output logic            irq,
    output logic [N_CH-1:0] irq_vec
);
    logic          wr;
    logic [CW-1:0] ch;
    logic [2:0]    offset;
    logic [31:0]   rd;
    ch_regs_t      sel;
    // padded to a power of two so unimplemented channels decode and read as zero
    ch_regs_t      regs [2**CW];

    assign wr           = chipselect & ~write_n;
    assign {ch, offset} = address;

    for (genvar i = 0; i < 2**CW; i++) begin : g_ch
        if (i < N_CH) begin : g_on
            tmc_nios2_mtimer_ch #(
                .CNT_W(CNT_W), .PRE_W(PRE_W), .RESET_PERIOD(RESET_PERIOD)
            ) u_ch (
                .clk(clk), .reset_n(reset_n), .wr(wr & (ch == CW'(i))),
                .offset(offset), .writedata(writedata), .regs(regs[i])
            );
            assign irq_vec[i] = regs[i].to & regs[i].ito;
        end else begin : g_off
            assign regs[i] = '0;
        end
    end

    always_comb begin
        sel = regs[ch];
        rd  = (offset == REG_STATUS)   ? {30'd0, sel.run, sel.to}   :
              (offset == REG_CONTROL)  ? {30'd0, sel.cont, sel.ito} :
              (offset == REG_PERIOD)   ? sel.period                 :
              (offset == REG_SNAPSHOT) ? sel.snapshot               :
              (offset == REG_PRESCALE) ? {16'd0, sel.prescale}      : '0;
    end

    always_ff @(posedge clk) readdata <= reset_n ? rd : '0;

    assign irq = |irq_vec;
endmodule

// File: tb/tb_tmc_nios2_mtimer.sv
// tb_tmc_nios2_mtimer: scoreboard bench with a behavioural timer model, directed scenarios and random traffic
module tb_tmc_nios2_mtimer;
    localparam int          N_CH = 4;
    localparam int          AW   = 5;
    localparam logic [31:0] RP   = 32'h08F0D17F;

    logic            clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
    logic [AW-1:0]   address = '0;
    logic [31:0]     writedata = '0, readdata;
    logic            irq;
    logic [N_CH-1:0] irq_vec;

    tmc_nios2_mtimer dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq(irq), .irq_vec(irq_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic [3:0]  iv;
    } exp_t;
    exp_t sb[$];
    int checks = 0, failures = 0;

    // behavioural model: one entry per channel, advanced once per clock edge
    bit [31:0] m_cnt[N_CH], m_prev[N_CH], m_per[N_CH], m_snap[N_CH];
    int        m_pre[N_CH], m_pact[N_CH], m_psc[N_CH];
    bit        m_ito[N_CH], m_cont[N_CH], m_to[N_CH], m_run[N_CH], m_pend[N_CH];

    function automatic logic [AW-1:0] ad(input int c, input int o);
        return AW'(c * 8 + o);
    endfunction

    function automatic logic [31:0] m_read(input logic [AW-1:0] a);
        int c;
        c = int'(a[4:3]);
        case (a[2:0])
            3'd0: return {30'd0, m_run[c], m_to[c]};
            3'd1: return {30'd0, m_cont[c], m_ito[c]};
            3'd2: return m_per[c];
            3'd3: return m_snap[c];
            3'd4: return 32'(m_pre[c]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] m_irq();
        logic [3:0] v;
        for (int c = 0; c < N_CH; c++) v[c] = m_to[c] & m_ito[c];
        return v;
    endfunction

    task automatic model_step(input bit rst, input logic [AW-1:0] a, input bit w, input logic [31:0] d);
        for (int c = 0; c < N_CH; c++) begin
            bit hit, zero, ev, tick, r;
            logic [2:0] o;
            hit = w && (int'(a[4:3]) == c);
            o   = a[2:0];
            if (rst) begin
                m_cnt[c] = RP; m_prev[c] = RP; m_per[c] = RP; m_snap[c] = 0;
                m_pre[c] = 0; m_pact[c] = 0; m_psc[c] = 0;
                m_ito[c] = 0; m_cont[c] = 0; m_to[c] = 0; m_run[c] = 0; m_pend[c] = 0;
            end else begin
                zero = m_cnt[c] == 0;
                ev   = zero && m_prev[c] != 0;
                tick = m_run[c] && m_psc[c] == m_pact[c];
                m_prev[c] = m_cnt[c];
                if (m_pend[c]) m_cnt[c] = m_per[c];
                else if (tick && !(ev && !m_cont[c])) m_cnt[c] = zero ? m_per[c] : m_cnt[c] - 32'd1;
                m_psc[c] = (!m_run[c] || m_pend[c] || tick) ? 0 : m_psc[c] + 1;
                if (tick || !m_run[c]) m_pact[c] = m_pre[c];
                r = m_run[c] && !(ev && !m_cont[c]) && !m_pend[c] && !(hit && o == 1 && d[3]);
                if (hit && o == 1 && d[2]) r = 1;
                m_to[c]   = ev || (m_to[c] && !(hit && o == 0 && d[0]));
                m_pend[c] = hit && o == 2;
                if (hit && o == 1) begin m_ito[c] = d[0]; m_cont[c] = d[1]; end
                if (hit && o == 2) m_per[c] = d;
                if (hit && o == 3) m_snap[c] = m_prev[c];
                if (hit && o == 4) m_pre[c] = int'(d[7:0]);
                m_run[c] = r;
            end
        end
    endtask

    // one bus clock; a non-empty name replaces the model's expectation with fixed values
    task automatic cyc(input logic [AW-1:0] a, input bit w, input logic [31:0] d,
                       input string name = "", input logic [31:0] xr = 0, input logic [3:0] xv = 0);
        exp_t e;
        address = a; chipselect = 1; write_n = !w; writedata = d;
        @(posedge clk);
        e.rd = reset_n ? m_read(a) : 32'd0;
        model_step(!reset_n, a, w, d);
        e.iv   = m_irq();
        e.name = "model";
        if (name != "") begin e.name = name; e.rd = xr; e.iv = xv; end
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        exp_t me;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                me = sb.pop_front();
                chk({me.name, " readdata"}, readdata, me.rd);
                chk({me.name, " irq_vec"}, 32'(irq_vec), 32'(me.iv));
                chk({me.name, " irq"}, 32'(irq), 32'(|me.iv));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rc, ro;
        bit rw;
        logic [31:0] rdw;
        @(negedge clk);
        reset_n = 0;
        repeat (3) cyc(ad(0, 2), 0, 0, "reset", 0, 0);
        reset_n = 1;
        cyc(ad(0, 0), 0, 0, "rst STATUS", 0, 0);
        cyc(ad(0, 1), 0, 0, "rst CONTROL", 0, 0);
        cyc(ad(0, 2), 0, 0, "rst PERIOD", RP, 0);
        cyc(ad(0, 3), 0, 0, "rst SNAPSHOT", 0, 0);
        cyc(ad(0, 4), 0, 0, "rst PRESCALE", 0, 0);
        // ch0 continuous, period 4, prescale 0
        cyc(ad(0, 2), 1, 4);
        cyc(ad(0, 4), 1, 0);
        cyc(ad(0, 1), 1, 7);
        repeat (4) cyc(ad(0, 0), 0, 0);
        cyc(ad(0, 0), 0, 0, "ch0 TO at +5", 2, 4'b0001);
        cyc(ad(0, 0), 1, 1, "ch0 clear", 3, 4'b0000);
        repeat (3) cyc(ad(0, 0), 0, 0);
        cyc(ad(0, 0), 0, 0, "ch0 TO at +10", 2, 4'b0001);
        repeat (4) cyc(ad(0, 0), 0, 0);
        cyc(ad(0, 0), 1, 1, "clear vs timeout", 3, 4'b0001);
        cyc(ad(0, 0), 1, 1, "lone clear", 3, 4'b0000);
        cyc(ad(0, 0), 0, 0, "ch0 TO low", 2, 4'b0000);
        cyc(ad(0, 1), 1, 8);
        cyc(ad(0, 0), 1, 1);
        // ch1 one-shot, period 3, prescale 2
        cyc(ad(1, 2), 1, 3);
        cyc(ad(1, 4), 1, 2);
        cyc(ad(1, 1), 1, 5);
        repeat (13) cyc(ad(1, 0), 0, 0);
        cyc(ad(1, 3), 1, 0);
        cyc(ad(1, 3), 0, 0, "ch1 held at 0", 0, 4'b0010);
        cyc(ad(1, 0), 0, 0, "ch1 one-shot status", 1, 4'b0010);
        // ch2 PERIOD write while running, START+STOP, START beats reload
        cyc(ad(2, 1), 1, 4);
        repeat (3) cyc(ad(2, 0), 0, 0);
        cyc(ad(2, 2), 1, 10);
        cyc(ad(2, 0), 0, 0);
        cyc(ad(2, 0), 0, 0, "ch2 RUN cleared", 0, 4'b0010);
        cyc(ad(2, 3), 1, 0);
        cyc(ad(2, 3), 0, 0, "ch2 counter=10", 10, 4'b0010);
        cyc(ad(2, 1), 1, 12);
        cyc(ad(2, 0), 0, 0, "ch2 START+STOP", 2, 4'b0010);
        cyc(ad(2, 2), 1, 10);
        cyc(ad(2, 1), 1, 4);
        cyc(ad(2, 0), 0, 0, "ch2 START beats reload", 2, 4'b0010);
        // ch3 snapshot of a running counter, reserved offsets
        cyc(ad(3, 2), 1, 32'h100);
        cyc(ad(3, 0), 0, 0);
        cyc(ad(3, 1), 1, 4);
        cyc(ad(3, 3), 1, 0);
        cyc(ad(3, 3), 0, 0, "ch3 snapshot", 32'h100, 4'b0010);
        cyc(ad(3, 5), 0, 0, "reserved 5", 0, 4'b0010);
        cyc(ad(3, 7), 1, 32'hFFFF_FFFF, "reserved 7", 0, 4'b0010);
        // one-clock reset mid-count
        reset_n = 0;
        cyc(ad(3, 0), 0, 0, "mid reset", 0, 0);
        reset_n = 1;
        cyc(ad(3, 2), 0, 0, "post-reset PERIOD", RP, 0);
        cyc(ad(3, 0), 0, 0, "post-reset STATUS", 0, 0);
        repeat (6) cyc(ad(1, 0), 0, 0, "no spurious irq", 0, 0);
        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rc  = $urandom_range(0, 3);
            ro  = $urandom_range(0, 7);
            rw  = ($urandom_range(0, 2) == 0);
            rdw = $urandom;
            if (ro == 1) rdw = $urandom_range(0, 15);
            if (ro == 2) rdw = $urandom_range(0, 12);
            if (ro == 4) rdw = $urandom_range(0, 3);
            if ($urandom_range(0, 599) == 0) reset_n = 0;
            cyc(ad(rc, ro), rw, rdw);
            reset_n = 1;
        end
        chipselect = 0;
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
